// File: rtl/pss_tx_generator.sv
// PSS transmit generator: on an accepted start, streams one time-domain PSS
// OFDM symbol (cyclic prefix, full symbol, zero guard gap) as AXI-stream samples.
module pss_tx_generator #(
   parameter int OUT_DW  = 32,
   parameter int TAP_DW  = 32,
   parameter int PSS_LEN = 128,
   parameter int CP_LEN  = 9,
   parameter int GAP_LEN = 0,
   parameter logic [TAP_DW*PSS_LEN-1:0] PSS_LOCAL_0 = '0,
   parameter logic [TAP_DW*PSS_LEN-1:0] PSS_LOCAL_1 = '0,
   parameter logic [TAP_DW*PSS_LEN-1:0] PSS_LOCAL_2 = '0
) (
   input  logic              clk_i,
   input  logic              reset_ni,
   input  logic              start_i,
   input  logic [1:0]        N_id_2_i,
   output logic [OUT_DW-1:0] m_axis_out_tdata,
   output logic              m_axis_out_tvalid,
   input  logic              m_axis_out_tready,
   output logic              m_axis_out_tlast,
   output logic              busy_o,
   output logic              done_o,
   output logic              invalid_o
);

   localparam int IW = (PSS_LEN > 1) ? $clog2(PSS_LEN) : 1;
   localparam int GW = (GAP_LEN > 1) ? $clog2(GAP_LEN) : 1;

   // First CP index; when CP_LEN is 0 the CP state is never entered
   localparam logic [IW-1:0] IDX_LAST = IW'(PSS_LEN - 1);
   localparam logic [IW-1:0] CP_FIRST = IW'(PSS_LEN - CP_LEN);
   localparam logic [GW-1:0] GAP_LAST = GW'((GAP_LEN > 0) ? GAP_LEN - 1 : 0);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_CP,
      ST_SYM,
      ST_GAP
   } state_t;

   state_t            state, state_next;
   logic [IW-1:0]     idx, idx_next, idx_inc;
   logic [GW-1:0]     gap_cnt, gap_next, gap_inc;
   logic [1:0]        nid, nid_next;
   logic [OUT_DW-1:0] data_next;
   logic              valid_next;
   logic              last_next;
   logic              done_next;
   logic              invalid_next;
   logic              handshake;

   // Bit-exact sample lookup from the stored sequence selected by N_id_2
   function automatic logic [OUT_DW-1:0] fetch(input logic [1:0] sel, input logic [IW-1:0] k);
      case (sel)
         2'd0:    fetch = OUT_DW'(PSS_LOCAL_0[int'(k)*TAP_DW +: TAP_DW]);
         2'd1:    fetch = OUT_DW'(PSS_LOCAL_1[int'(k)*TAP_DW +: TAP_DW]);
         2'd2:    fetch = OUT_DW'(PSS_LOCAL_2[int'(k)*TAP_DW +: TAP_DW]);
         default: fetch = '0;
      endcase
   endfunction

   // State, counters and the registered output stage
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state             <= ST_IDLE;
         idx               <= '0;
         gap_cnt           <= '0;
         nid               <= '0;
         m_axis_out_tdata  <= '0;
         m_axis_out_tvalid <= 1'b0;
         m_axis_out_tlast  <= 1'b0;
         done_o            <= 1'b0;
         invalid_o         <= 1'b0;
      end else begin
         state             <= state_next;
         idx               <= idx_next;
         gap_cnt           <= gap_next;
         nid               <= nid_next;
         m_axis_out_tdata  <= data_next;
         m_axis_out_tvalid <= valid_next;
         m_axis_out_tlast  <= last_next;
         done_o            <= done_next;
         invalid_o         <= invalid_next;
      end
   end

   // Next-state logic: each handshake advances to the next sample and preloads it
   always_comb begin
      state_next   = state;
      idx_next     = idx;
      gap_next     = gap_cnt;
      nid_next     = nid;
      data_next    = m_axis_out_tdata;
      valid_next   = m_axis_out_tvalid;
      last_next    = m_axis_out_tlast;
      done_next    = 1'b0;
      invalid_next = 1'b0;
      handshake    = m_axis_out_tvalid && m_axis_out_tready;
      idx_inc      = idx + 1'b1;
      gap_inc      = gap_cnt + 1'b1;

      case (state)
         ST_IDLE: begin
            if (start_i) begin
               if (N_id_2_i == 2'd3) begin
                  invalid_next = 1'b1;
               end else begin
                  nid_next   = N_id_2_i;
                  valid_next = 1'b1;
                  last_next  = 1'b0;
                  if (CP_LEN > 0) begin
                     state_next = ST_CP;
                     idx_next   = CP_FIRST;
                     data_next  = fetch(N_id_2_i, CP_FIRST);
                  end else begin
                     state_next = ST_SYM;
                     idx_next   = '0;
                     data_next  = fetch(N_id_2_i, '0);
                  end
               end
            end
         end

         ST_CP: begin
            if (handshake) begin
               if (idx == IDX_LAST) begin
                  state_next = ST_SYM;
                  idx_next   = '0;
                  data_next  = fetch(nid, '0);
               end else begin
                  idx_next  = idx_inc;
                  data_next = fetch(nid, idx_inc);
               end
            end
         end

         ST_SYM: begin
            if (handshake) begin
               if (idx == IDX_LAST) begin
                  if (GAP_LEN > 0) begin
                     state_next = ST_GAP;
                     gap_next   = '0;
                     data_next  = '0;
                     last_next  = (GAP_LAST == '0);
                  end else begin
                     state_next = ST_IDLE;
                     idx_next   = '0;
                     data_next  = '0;
                     valid_next = 1'b0;
                     last_next  = 1'b0;
                     done_next  = 1'b1;
                  end
               end else begin
                  idx_next  = idx_inc;
                  data_next = fetch(nid, idx_inc);
                  last_next = (GAP_LEN == 0) && (idx_inc == IDX_LAST);
               end
            end
         end

         ST_GAP: begin
            if (handshake) begin
               if (gap_cnt == GAP_LAST) begin
                  state_next = ST_IDLE;
                  idx_next   = '0;
                  gap_next   = '0;
                  data_next  = '0;
                  valid_next = 1'b0;
                  last_next  = 1'b0;
                  done_next  = 1'b1;
               end else begin
                  gap_next  = gap_inc;
                  last_next = (gap_inc == GAP_LAST);
               end
            end
         end

         default: begin
            state_next = ST_IDLE;
            valid_next = 1'b0;
            last_next  = 1'b0;
         end
      endcase
   end

   assign busy_o = (state != ST_IDLE);

endmodule

// File: tb/tb_pss_tx_generator.sv
// Scoreboard bench for pss_tx_generator: stimulus pushes expected frames,
// per-DUT monitors pop and compare on every handshake.
module tb_pss_tx_generator;

   localparam int PSS_LEN = 8;
   localparam int CP_LEN  = 2;
   localparam int GAP_LEN = 3;
   localparam int DW      = 32;

   // Reference sample: imag = k, real = k+16, offset by 0x0100_0100 per N_id_2
   function automatic logic [31:0] model_sample(input int nid, input int k);
      logic [15:0] im;
      logic [15:0] re;
      im = 16'(k);
      re = 16'(k + 16);
      return {im, re} + 32'(nid) * 32'h0100_0100;
   endfunction

   function automatic logic [DW*PSS_LEN-1:0] build_table(input int nid);
      logic [DW*PSS_LEN-1:0] t;
      t = '0;
      for (int k = 0; k < PSS_LEN; k++) t[k*DW +: DW] = model_sample(nid, k);
      return t;
   endfunction

   localparam logic [DW*PSS_LEN-1:0] TAB0 = build_table(0);
   localparam logic [DW*PSS_LEN-1:0] TAB1 = build_table(1);
   localparam logic [DW*PSS_LEN-1:0] TAB2 = build_table(2);

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start_a = 1'b0, start_b = 1'b0;
   logic [1:0]    nid_a = 2'd0, nid_b = 2'd0;
   logic          tready_a = 1'b1, tready_b = 1'b1;
   logic [DW-1:0] tdata_a, tdata_b;
   logic          tvalid_a, tvalid_b, tlast_a, tlast_b;
   logic          busy_a, busy_b, done_a, done_b, inv_a, inv_b;

   int checks = 0;
   int errors = 0;
   int hs_a = 0, hs_b = 0, busy_cnt_a = 0;
   bit rand_ready = 0;
   logic [32:0] qa[$];
   logic [32:0] qb[$];

   always #5 clk = ~clk;

   pss_tx_generator #(.OUT_DW(DW), .TAP_DW(DW), .PSS_LEN(PSS_LEN), .CP_LEN(CP_LEN),
      .GAP_LEN(GAP_LEN), .PSS_LOCAL_0(TAB0), .PSS_LOCAL_1(TAB1), .PSS_LOCAL_2(TAB2)) dut_a (
      .clk_i(clk), .reset_ni(rst_n), .start_i(start_a), .N_id_2_i(nid_a),
      .m_axis_out_tdata(tdata_a), .m_axis_out_tvalid(tvalid_a), .m_axis_out_tready(tready_a),
      .m_axis_out_tlast(tlast_a), .busy_o(busy_a), .done_o(done_a), .invalid_o(inv_a));

   pss_tx_generator #(.OUT_DW(DW), .TAP_DW(DW), .PSS_LEN(PSS_LEN), .CP_LEN(0),
      .GAP_LEN(0), .PSS_LOCAL_0(TAB0), .PSS_LOCAL_1(TAB1), .PSS_LOCAL_2(TAB2)) dut_b (
      .clk_i(clk), .reset_ni(rst_n), .start_i(start_b), .N_id_2_i(nid_b),
      .m_axis_out_tdata(tdata_b), .m_axis_out_tvalid(tvalid_b), .m_axis_out_tready(tready_b),
      .m_axis_out_tlast(tlast_b), .busy_o(busy_b), .done_o(done_b), .invalid_o(inv_b));

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
      end
   endtask

   // Expected frame built from the frame rules: CP tail, full symbol, zero gap
   task automatic pushFrame(input int dut, input int nid);
      int cp, gap, total;
      logic [31:0] s;
      cp = (dut == 0) ? CP_LEN : 0;
      gap = (dut == 0) ? GAP_LEN : 0;
      total = cp + PSS_LEN + gap;
      for (int i = 0; i < total; i++) begin
         if (i < cp) s = model_sample(nid, PSS_LEN - cp + i);
         else if (i < cp + PSS_LEN) s = model_sample(nid, i - cp);
         else s = 32'h0;
         if (dut == 0) qa.push_back({(i == total - 1), s});
         else qb.push_back({(i == total - 1), s});
      end
   endtask

   task automatic applyStimulus(input int dut, input int nid, input bit expect_frame);
      if (expect_frame) pushFrame(dut, nid);
      @(posedge clk);
      #1;
      if (dut == 0) begin start_a = 1'b1; nid_a = 2'(nid); end
      else begin start_b = 1'b1; nid_b = 2'(nid); end
      @(posedge clk);
      #1;
      start_a = 1'b0;
      start_b = 1'b0;
   endtask

   task automatic waitDone(input int dut, input int max_cycles);
      bit seen;
      seen = 0;
      for (int i = 0; i < max_cycles; i++) begin
         @(negedge clk);
         if ((dut == 0) ? done_a : done_b) begin
            seen = 1;
            break;
         end
      end
      if (!seen) begin
         checks++;
         errors++;
         $display("[TB] FAIL done_timeout dut=%0d actual=no_done required=done", dut);
      end
   endtask

   // Random or always-ready downstream for DUT A
   always @(posedge clk) begin
      #1;
      tready_a = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   // Monitor for DUT A: scoreboard pops, stall stability and done placement
   logic        last_seen_a = 1'b0, prev_stall_a = 1'b0;
   logic [32:0] prev_item_a = '0;
   always @(negedge clk) begin
      if (!rst_n) begin
         last_seen_a  = 1'b0;
         prev_stall_a = 1'b0;
      end else begin
         if (done_a || last_seen_a) checkOutput("done_after_tlast_a", done_a, last_seen_a);
         if (busy_a) busy_cnt_a++;
         if (prev_stall_a) checkOutput("stall_hold_a", {tvalid_a, tlast_a, tdata_a}, {1'b1, prev_item_a});
         last_seen_a = 1'b0;
         if (tvalid_a && tready_a) begin
            hs_a++;
            if (qa.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL unexpected_sample_a actual=%0h required=none", tdata_a);
            end else begin
               checkOutput("sample_a", {tlast_a, tdata_a}, qa.pop_front());
            end
            last_seen_a = tlast_a;
         end
         prev_stall_a = tvalid_a && !tready_a;
         prev_item_a  = {tlast_a, tdata_a};
      end
   end

   // Monitor for DUT B (no CP, no gap)
   logic last_seen_b = 1'b0;
   always @(negedge clk) begin
      if (!rst_n) begin
         last_seen_b = 1'b0;
      end else begin
         if (done_b || last_seen_b) checkOutput("done_after_tlast_b", done_b, last_seen_b);
         last_seen_b = 1'b0;
         if (tvalid_b && tready_b) begin
            hs_b++;
            if (qb.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL unexpected_sample_b actual=%0h required=none", tdata_b);
            end else begin
               checkOutput("sample_b", {tlast_b, tdata_b}, qb.pop_front());
            end
            last_seen_b = tlast_b;
         end
      end
   end

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog actual=running required=finished");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int nid;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("reset_state_a", {tvalid_a, tlast_a, busy_a, done_a, inv_a, tdata_a}, 64'h0);
      checkOutput("reset_state_b", {tvalid_b, tlast_b, busy_b, done_b, inv_b, tdata_b}, 64'h0);
      rst_n = 1'b1;

      $display("[TB] basic frame N_id_2=0");
      busy_cnt_a = 0;
      hs_a = 0;
      applyStimulus(0, 0, 1);
      waitDone(0, 60);
      checkOutput("busy_cycles", 64'(busy_cnt_a), 64'd13);
      checkOutput("handshakes_basic", 64'(hs_a), 64'd13);

      $display("[TB] backpressure N_id_2=2");
      rand_ready = 1;
      hs_a = 0;
      applyStimulus(0, 2, 1);
      waitDone(0, 400);
      rand_ready = 0;
      checkOutput("handshakes_bp", 64'(hs_a), 64'd13);

      $display("[TB] randomized frames");
      for (int r = 0; r < 4; r++) begin
         nid = int'($urandom_range(0, 2));
         rand_ready = 1'($urandom_range(0, 1));
         hs_a = 0;
         applyStimulus(0, nid, 1);
         waitDone(0, 400);
         rand_ready = 0;
         checkOutput("handshakes_rand", 64'(hs_a), 64'd13);
      end

      $display("[TB] invalid N_id_2=3");
      @(posedge clk);
      #1;
      start_a = 1'b1;
      nid_a = 2'd3;
      @(posedge clk);
      #1;
      start_a = 1'b0;
      @(negedge clk);
      checkOutput("invalid_pulse", inv_a, 1'b1);
      checkOutput("invalid_no_valid", {tvalid_a, busy_a}, 2'b00);
      @(negedge clk);
      checkOutput("invalid_one_cycle", {inv_a, tvalid_a}, 2'b00);

      $display("[TB] start ignored while busy");
      hs_a = 0;
      applyStimulus(0, 0, 1);
      repeat (4) @(posedge clk);
      #1;
      start_a = 1'b1;
      nid_a = 2'd1;
      @(posedge clk);
      #1;
      start_a = 1'b0;
      waitDone(0, 60);
      checkOutput("handshakes_ignored", 64'(hs_a), 64'd13);

      $display("[TB] reset mid-frame");
      hs_a = 0;
      applyStimulus(0, 1, 1);
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (hs_a >= 5) break;
      end
      checkOutput("reached_5_handshakes", 64'(hs_a), 64'd5);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("async_reset_outputs", {tvalid_a, tlast_a, busy_a, done_a, tdata_a}, 64'h0);
      qa.delete();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checkOutput("no_done_in_reset", {done_a, tvalid_a}, 2'b00);
      end
      @(posedge clk);
      #3;
      rst_n = 1'b1;
      @(negedge clk);
      checkOutput("no_done_after_release", {done_a, busy_a}, 2'b00);
      hs_a = 0;
      applyStimulus(0, 1, 1);
      waitDone(0, 60);
      checkOutput("handshakes_after_reset", 64'(hs_a), 64'd13);

      $display("[TB] CP_LEN=0 GAP_LEN=0 instance");
      hs_b = 0;
      applyStimulus(1, 2, 1);
      waitDone(1, 60);
      checkOutput("handshakes_b", 64'(hs_b), 64'd8);

      $display("[TB] back-to-back start");
      hs_a = 0;
      pushFrame(0, 1);
      pushFrame(0, 1);
      @(posedge clk);
      #1;
      start_a = 1'b1;
      nid_a = 2'd1;
      waitDone(0, 60);
      checkOutput("idle_between_frames", tvalid_a, 1'b0);
      @(posedge clk);
      #1;
      start_a = 1'b0;
      @(negedge clk);
      checkOutput("restart_valid", {tvalid_a, busy_a}, 2'b11);
      waitDone(0, 60);
      checkOutput("handshakes_b2b", 64'(hs_a), 64'd26);

      repeat (3) @(negedge clk);
      checkOutput("queue_a_empty", 64'(qa.size()), 64'd0);
      checkOutput("queue_b_empty", 64'(qb.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
